// File: rtl/btn_event_encoder_pkg.sv
// Shared key/FSM definitions for the button event encoder.
// Holds the key count, value code width, FSM encoding and key-priority helpers.
package btn_event_encoder_pkg;

    localparam int KEY_COUNT = 11;
    localparam int VALUE_W   = 4;

    typedef logic [1:0]           state_t;
    typedef logic [KEY_COUNT-1:0] key_vec_t;
    typedef logic [VALUE_W-1:0]   key_code_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_HELD    = 2'd1;
    localparam state_t ST_LOCKOUT = 2'd2;

    // Key i maps to code i+1 so that code 0 can mean "nothing captured".
    function automatic key_code_t lowest_key_code(input key_vec_t keys);
        key_code_t code;
        code = '0;
        for (int i = KEY_COUNT - 1; i >= 0; i--) begin
            if (keys[i]) begin
                code = VALUE_W'(i + 1);
            end
        end
        return code;
    endfunction

    function automatic key_vec_t lowest_key_mask(input key_vec_t keys);
        return keys & (~keys + KEY_COUNT'(1));
    endfunction

endpackage

// File: rtl/btn_debounce_bit.sv
// One-key conditioner: 2-flop synchronizer, tick-paced sample shift register
// and the resulting debounced level.
module btn_debounce_bit #(
    parameter int DEB_SAMPLES = 4
) (
    input  logic clk_1mhz,
    input  logic rst,
    input  logic tick,
    input  logic btn_raw,
    output logic deb_level
);

    logic                   sync1_q, sync1_d;
    logic                   sync2_q, sync2_d;
    logic [DEB_SAMPLES-1:0] samples_q, samples_d;
    logic                   deb_q, deb_d;

    // The level only moves once the whole sample window agrees.
    always_comb begin
        sync1_d   = btn_raw;
        sync2_d   = sync1_q;
        samples_d = samples_q;
        deb_d     = deb_q;
        if (tick) begin
            samples_d = (samples_q << 1) | DEB_SAMPLES'(sync2_q);
            if (&samples_d) begin
                deb_d = 1'b1;
            end else if (~|samples_d) begin
                deb_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_1mhz) begin
        if (rst) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            samples_q <= '0;
            deb_q     <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            samples_q <= samples_d;
            deb_q     <= deb_d;
        end
    end

    assign deb_level = deb_q;

endmodule

// File: rtl/btn_event_encoder.sv
// Keypad front end: debounces 11 keys and reports one captured key at a time,
// requiring a full release of every key before the next capture.
module btn_event_encoder
    import btn_event_encoder_pkg::*;
#(
    parameter int TICK_DIV    = 1000,
    parameter int DEB_SAMPLES = 4
) (
    input  logic                 clk_1mhz,
    input  logic                 rst,
    input  logic [KEY_COUNT-1:0] btn_in,
    output logic                 button_pressed,
    output logic [VALUE_W-1:0]   button_value,
    output logic [KEY_COUNT-1:0] deb_state
);

    localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    logic [CNT_W-1:0] tick_cnt_q, tick_cnt_d;
    logic             tick;

    always_comb begin
        tick       = (tick_cnt_q == CNT_W'(TICK_DIV - 1));
        tick_cnt_d = tick ? '0 : tick_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk_1mhz) begin
        if (rst) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    for (genvar k = 0; k < KEY_COUNT; k++) begin : g_key
        btn_debounce_bit #(
            .DEB_SAMPLES(DEB_SAMPLES)
        ) u_deb (
            .clk_1mhz (clk_1mhz),
            .rst      (rst),
            .tick     (tick),
            .btn_raw  (btn_in[k]),
            .deb_level(deb_state[k])
        );
    end

    state_t    state_q, state_d;
    logic      pressed_q, pressed_d;
    key_code_t value_q, value_d;
    key_vec_t  key_mask_q, key_mask_d;

    // The captured key is kept one-hot so HELD can watch just that key.
    always_comb begin
        state_d    = state_q;
        value_d    = value_q;
        key_mask_d = key_mask_q;
        case (state_q)
            ST_IDLE: begin
                if (|deb_state) begin
                    state_d    = ST_HELD;
                    value_d    = lowest_key_code(deb_state);
                    key_mask_d = lowest_key_mask(deb_state);
                end
            end
            ST_HELD: begin
                if (~|(deb_state & key_mask_q)) begin
                    state_d = ST_LOCKOUT;
                end
            end
            ST_LOCKOUT: begin
                if (~|deb_state) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        pressed_d = (state_d == ST_HELD);
    end

    always_ff @(posedge clk_1mhz) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            pressed_q  <= 1'b0;
            value_q    <= '0;
            key_mask_q <= '0;
        end else begin
            state_q    <= state_d;
            pressed_q  <= pressed_d;
            value_q    <= value_d;
            key_mask_q <= key_mask_d;
        end
    end

    assign button_pressed = pressed_q;
    assign button_value   = value_q;

endmodule

// File: tb/tb_btn_event_encoder.sv
// Scoreboard bench for btn_event_encoder: stimulus queues expected output
// events, a negedge monitor pops one whenever {button_pressed, button_value} changes.
`timescale 1ns/1ps
module tb_btn_event_encoder;
    import btn_event_encoder_pkg::*;

    logic                 clk_1mhz = 1'b0;
    logic                 rst;
    logic [KEY_COUNT-1:0] btn_in;
    logic                 button_pressed;
    logic [VALUE_W-1:0]   button_value;
    logic [KEY_COUNT-1:0] deb_state;

    btn_event_encoder #(
        .TICK_DIV   (10),
        .DEB_SAMPLES(4)
    ) dut (
        .clk_1mhz      (clk_1mhz),
        .rst           (rst),
        .btn_in        (btn_in),
        .button_pressed(button_pressed),
        .button_value  (button_value),
        .deb_state     (deb_state)
    );

    always #500 clk_1mhz = ~clk_1mhz;

    typedef struct {
        logic       pressed;
        logic [3:0] value;
        string      name;
    } evt_t;

    evt_t       exp_q[$];
    evt_t       mon_exp;
    logic [4:0] mon_cur;
    logic [4:0] mon_prev;
    bit         mon_en     = 1'b0;
    bit         watch_key3 = 1'b0;
    bit         key3_seen  = 1'b0;
    int         vectors     = 0;
    int         miscompares = 0;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, actual, expected);
        end
    endtask

    task automatic expectEvent(input logic pressed, input logic [3:0] value, input string name);
        evt_t e;
        e.pressed = pressed;
        e.value   = value;
        e.name    = name;
        exp_q.push_back(e);
    endtask

    task automatic applyStimulus(input logic [KEY_COUNT-1:0] keys);
        @(posedge clk_1mhz);
        #1 btn_in = keys;
    endtask

    task automatic waitPressed(input logic level, input int budget, input string name);
        bit found;
        found = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk_1mhz);
            if (button_pressed === level) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput(name, 16'(found), 16'(1));
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_1mhz);
    endtask

    // Any change on the event outputs must match the next queued expectation.
    always @(negedge clk_1mhz) begin
        if (watch_key3 && (deb_state[3] !== 1'b0 || button_pressed !== 1'b0)) begin
            key3_seen = 1'b1;
        end
        if (mon_en) begin
            mon_cur = {button_pressed, button_value};
            if (mon_cur !== mon_prev) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("[TB] FAIL unexpected_event: got pressed=%0b value=%0d, required no change",
                             button_pressed, button_value);
                end else begin
                    mon_exp = exp_q.pop_front();
                    checkOutput(mon_exp.name, 16'(mon_cur), 16'({mon_exp.pressed, mon_exp.value}));
                end
                mon_prev = mon_cur;
            end
        end
    end

    initial begin
        #20_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, required finish before 20 ms");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst    = 1'b1;
        btn_in = '0;
        repeat (3) @(posedge clk_1mhz);
        #1 rst = 1'b0;
        @(negedge clk_1mhz);
        checkOutput("reset_pressed", 16'(button_pressed), 16'(0));
        checkOutput("reset_value", 16'(button_value), 16'(0));
        checkOutput("reset_deb_state", 16'(deb_state), 16'(0));
        mon_prev = {button_pressed, button_value};
        mon_en   = 1'b1;

        // Long press of key 9
        expectEvent(1'b1, 4'd10, "a_press_key9");
        applyStimulus(11'h200);
        waitPressed(1'b1, 44, "a_press_latency");
        idle(5);
        checkOutput("a_deb_state", 16'(deb_state), 16'(11'h200));
        idle(50);
        expectEvent(1'b0, 4'd10, "a_release_key9");
        applyStimulus(11'h000);
        waitPressed(1'b0, 44, "a_release_latency");
        idle(20);

        // Key 3 toggling every 15 cycles never fills the sample window
        watch_key3 = 1'b1;
        for (int c = 0; c < 200; c++) begin
            applyStimulus(((c / 15) % 2 == 0) ? 11'h008 : 11'h000);
        end
        applyStimulus(11'h000);
        idle(50);
        watch_key3 = 1'b0;
        checkOutput("b_bounce_key3_seen", 16'(key3_seen), 16'(0));
        checkOutput("b_value_kept", 16'(button_value), 16'(10));

        // Keys 2 and 5 together: lowest wins, key 5 locked out until full release
        expectEvent(1'b1, 4'd3, "c_press_key2");
        applyStimulus(11'h024);
        waitPressed(1'b1, 44, "c_press_latency");
        idle(30);
        checkOutput("c_deb_both", 16'(deb_state), 16'(11'h024));
        expectEvent(1'b0, 4'd3, "c_release_key2_lockout");
        applyStimulus(11'h020);
        waitPressed(1'b0, 44, "c_release_latency");
        idle(60);
        checkOutput("c_lockout_pressed", 16'(button_pressed), 16'(0));
        checkOutput("c_key5_still_deb", 16'(deb_state), 16'(11'h020));
        applyStimulus(11'h000);
        idle(60);
        expectEvent(1'b1, 4'd6, "c_repress_key5");
        applyStimulus(11'h020);
        waitPressed(1'b1, 44, "c_repress_latency");
        expectEvent(1'b0, 4'd6, "c_release_key5");
        applyStimulus(11'h000);
        waitPressed(1'b0, 44, "c_release5_latency");
        idle(20);

        // Key 0 then key 7: two separate pulses
        expectEvent(1'b1, 4'd1, "d_press_key0");
        applyStimulus(11'h001);
        waitPressed(1'b1, 44, "d_press0_latency");
        idle(10);
        expectEvent(1'b0, 4'd1, "d_release_key0");
        applyStimulus(11'h000);
        waitPressed(1'b0, 44, "d_release0_latency");
        idle(20);
        expectEvent(1'b1, 4'd8, "d_press_key7");
        applyStimulus(11'h080);
        waitPressed(1'b1, 44, "d_press7_latency");
        idle(10);
        expectEvent(1'b0, 4'd8, "d_release_key7");
        applyStimulus(11'h000);
        waitPressed(1'b0, 44, "d_release7_latency");
        idle(20);

        // Reset during HELD with key 4 still down, then recapture
        expectEvent(1'b1, 4'd5, "e_press_key4");
        applyStimulus(11'h010);
        waitPressed(1'b1, 44, "e_press_latency");
        idle(10);
        expectEvent(1'b0, 4'd0, "e_reset_clears");
        expectEvent(1'b1, 4'd5, "e_recapture_key4");
        @(posedge clk_1mhz);
        #1 rst = 1'b1;
        @(posedge clk_1mhz);
        #1 rst = 1'b0;
        @(negedge clk_1mhz);
        checkOutput("e_reset_pressed", 16'(button_pressed), 16'(0));
        checkOutput("e_reset_value", 16'(button_value), 16'(0));
        waitPressed(1'b1, 44, "e_recapture_latency");
        idle(10);
        expectEvent(1'b0, 4'd5, "e_release_key4");
        applyStimulus(11'h000);
        waitPressed(1'b0, 44, "e_release_latency");
        idle(20);

        checkOutput("queue_drained", 16'(exp_q.size()), 16'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/btn_event_encoder.md
BTN_EVENT_ENCODER -- requirements
Module: btn_event_encoder

Interface
REQ-001 Parameter TICK_DIV, default 1000: clk_1mhz cycles per debounce sample tick (1 ms).
REQ-002 Parameter DEB_SAMPLES, default 4: number of consecutive equal samples needed to change a debounced key state.
REQ-003 clk_1mhz  in  1  sole clock, 1 MHz.
REQ-004 rst  in  1  reset; one clock, reset is synchronous and active-high.
REQ-005 btn_in  in  11  raw asynchronous key inputs, active-high, bit i = key i.
REQ-006 button_pressed  out  1  level; high while the captured key is held (debounced).
REQ-007 button_value  out  4  code of the captured key, i+1 for btn_in[i] (1..11); 0 = none captured since reset.
REQ-008 deb_state  out  11  debounced key levels, for the display and verification only.

Function
REQ-009 Each btn_in bit SHALL pass through a 2-flop synchronizer before any other use.
REQ-010 A tick counter SHALL count 0..TICK_DIV-1 and wrap, asserting tick for one cycle at count TICK_DIV-1.
REQ-011 On each tick, each key SHALL shift its synchronized level into a DEB_SAMPLES-bit sample register.
REQ-012 deb_state[i] SHALL go to 1 (or 0) in the cycle after a tick whose sample register is all ones (or all zeros); mixed samples hold deb_state[i].
REQ-013 FSM states: IDLE, HELD, LOCKOUT; encoding is defined in the shared package.
REQ-014 IDLE: when any deb_state bit is 1, latch the lowest set index i, set button_value=i+1, and go to HELD.
REQ-015 HELD: button_pressed=1; all other keys are ignored; when deb_state of the captured key is 0, go to LOCKOUT.
REQ-016 LOCKOUT: button_pressed=0; return to IDLE only when all deb_state bits are 0.
REQ-017 button_pressed SHALL be registered and equal 1 exactly while the FSM is in HELD.
REQ-018 button_value SHALL change only on the IDLE->HELD transition and SHALL hold through HELD, LOCKOUT and IDLE.
REQ-019 Latency: button_pressed rises 1 cycle after the deb_state rise that causes the capture.
REQ-020 Simultaneous debounced rises in one cycle: the lowest index wins, and the others need a full release (LOCKOUT) before they can be captured.
REQ-021 A key held through reset deassertion SHALL be captured normally once it has debounced (no lockout after reset).
REQ-022 Bounce shorter than DEB_SAMPLES ticks SHALL produce no change in deb_state or button_pressed.

Reset
REQ-023 Reset SHALL clear the synchronizers, sample registers, deb_state, the tick counter, button_pressed=0 and button_value=0, and set the FSM to IDLE.
REQ-024 Asserting rst mid-HELD SHALL drop button_pressed in the cycle after rst is sampled, and no event is replayed.

Structure
REQ-025 The FSM state encoding, KEY_COUNT=11 and the value code width (4) belong in the shared game package.
REQ-026 One sub-module, btn_debounce_bit, SHALL hold the synchronizer, sample register and deb_state for one key, instantiated 11 times; the tick counter is shared at top level.

Verification
REQ-027 Use TICK_DIV=10 and DEB_SAMPLES=4 for all scenarios below.
REQ-028 Hold btn_in[9] high for 100 cycles -> button_pressed=1 within 2+40+2 cycles, button_value=10, and the output holds until release is debounced.
REQ-029 Toggle btn_in[3] every 15 cycles for 200 cycles -> deb_state[3] and button_pressed stay 0 throughout.
REQ-030 Raise btn_in[2] and btn_in[5] in the same cycle -> button_value=3; release btn_in[2] with btn_in[5] still held -> button_pressed=0 (LOCKOUT), and no capture of key 5 until both keys are released and re-pressed.
REQ-031 Press key 0, release it, then press key 7 -> button_value goes 1 then 8, with button_pressed giving two separate high pulses separated by a low gap.
REQ-032 Assert rst for 1 cycle during HELD -> next cycle button_pressed=0, button_value=0, FSM=IDLE; if the key is still held, it is recaptured after debounce.
